// File: rtl/debug_dm_regs.sv
// Debug-module register file behind a DMI request/response port.
// Holds dmcontrol, dmstatus, abstractcs, command, sbcs and data0.. for one hart.
module debug_dm_regs #(
  parameter int DATACOUNT = 1,
  parameter int VERSION   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  // DMI request
  input  logic        dmi_req_valid,
  output logic        dmi_req_ready,
  input  logic [6:0]  dmi_req_addr,
  input  logic [31:0] dmi_req_data,
  input  logic [1:0]  dmi_req_op,
  // DMI response
  output logic        dmi_rsp_valid,
  input  logic        dmi_rsp_ready,
  output logic [31:0] dmi_rsp_data,
  output logic [1:0]  dmi_rsp_op,
  // hart
  input  logic        hart_halted,
  input  logic        hart_running,
  input  logic        hart_resumeack,
  output logic        hart_haltreq,
  output logic        hart_resumereq,
  output logic        dmactive,
  // abstract engine
  output logic        cmd_valid,
  output logic [31:0] cmd,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic [2:0]  cmd_err,
  input  logic        data_we,
  input  logic [3:0]  data_idx,
  input  logic [31:0] data_wdata
);

  localparam logic [6:0] A_DATA0      = 7'h04;
  localparam logic [6:0] A_DMCONTROL  = 7'h10;
  localparam logic [6:0] A_DMSTATUS   = 7'h11;
  localparam logic [6:0] A_ABSTRACTCS = 7'h16;
  localparam logic [6:0] A_COMMAND    = 7'h17;
  localparam logic [6:0] A_SBCS       = 7'h38;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;
  localparam logic [1:0] RSP_OK   = 2'd0;
  localparam logic [1:0] RSP_FAIL = 2'd2;

  typedef enum logic {S_IDLE, S_RESP} state_e;
  state_e state_q, state_d;

  logic                       dmactive_q, haltreq_q, resumereq_q, resumeack_q, cmd_valid_q;
  logic [2:0]                 cmderr_q;
  logic [31:0]                cmd_q, rsp_data_q;
  logic [1:0]                 rsp_op_q;
  logic [DATACOUNT-1:0][31:0] data_q;

  logic        req_fire, wr_en, rd_en, busy, hold;
  logic        dmctl_wr, dm_clear, acs_wr, cmd_wr, is_data, data_acc;
  logic [6:0]  data_off;
  logic [31:0] data_rd, rd_data, rsp_data_d;
  logic [31:0] dmstatus_v, abstractcs_v, dmcontrol_v;
  logic [1:0]  rsp_op_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dmi_req_valid) state_d = S_RESP;
      S_RESP:  if (dmi_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dmi_req_ready = (state_q == S_IDLE);
  assign dmi_rsp_valid = (state_q == S_RESP);

  // ---------------------------------------------------------------- decode
  assign req_fire = dmi_req_valid && (state_q == S_IDLE);
  assign wr_en    = req_fire && (dmi_req_op == OP_WRITE);
  assign rd_en    = req_fire && (dmi_req_op == OP_READ);
  assign busy     = cmd_busy || cmd_valid_q;

  assign data_off = dmi_req_addr - A_DATA0;
  assign is_data  = (dmi_req_addr >= A_DATA0) && (data_off < 7'(DATACOUNT));
  assign data_acc = (wr_en || rd_en) && is_data;

  assign dmctl_wr = wr_en && (dmi_req_addr == A_DMCONTROL);
  assign acs_wr   = wr_en && (dmi_req_addr == A_ABSTRACTCS);
  assign cmd_wr   = wr_en && (dmi_req_addr == A_COMMAND);
  // Deactivation clears this cycle; inactivity keeps everything pinned after.
  assign dm_clear = dmctl_wr && !dmi_req_data[0];
  assign hold     = !dmactive_q || dm_clear;

  // ---------------------------------------------------------------- read mux
  always_comb begin
    data_rd = '0;
    for (int j = 0; j < DATACOUNT; j++)
      if (data_off == 7'(j)) data_rd = data_q[j];
  end

  always_comb begin
    dmstatus_v        = '0;
    dmstatus_v[3:0]   = 4'(VERSION);
    dmstatus_v[7]     = 1'b1;
    dmstatus_v[9:8]   = {2{hart_halted}};
    dmstatus_v[11:10] = {2{hart_running}};
    dmstatus_v[17:16] = {2{resumeack_q}};
  end

  always_comb begin
    abstractcs_v       = '0;
    abstractcs_v[3:0]  = 4'(DATACOUNT);
    abstractcs_v[10:8] = cmderr_q;
    abstractcs_v[12]   = busy;
  end

  assign dmcontrol_v = {haltreq_q, 30'b0, dmactive_q};

  always_comb begin
    rd_data = '0;
    if (is_data) rd_data = data_rd;
    else begin
      case (dmi_req_addr)
        A_DMCONTROL:  rd_data = dmcontrol_v;
        A_DMSTATUS:   rd_data = dmstatus_v;
        A_ABSTRACTCS: rd_data = abstractcs_v;
        A_SBCS:       rd_data = {3'd1, 29'b0};
        default:      rd_data = '0;
      endcase
    end
  end

  always_comb begin
    rsp_op_d   = RSP_OK;
    rsp_data_d = '0;
    if (dmi_req_op == OP_RSVD) rsp_op_d = RSP_FAIL;
    else if (dmi_req_op == OP_READ) rsp_data_d = rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_op_q   <= RSP_OK;
    end else if (req_fire) begin
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
    end
  end

  assign dmi_rsp_data = rsp_data_q;
  assign dmi_rsp_op   = rsp_op_q;

  // ---------------------------------------------------------------- control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmactive_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      resumeack_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmderr_q    <= '0;
      cmd_q       <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (dmctl_wr) begin
        dmactive_q <= dmi_req_data[0];
        haltreq_q  <= dmi_req_data[31] && dmi_req_data[0];
      end
      if (hold) begin
        resumereq_q <= 1'b0;
        resumeack_q <= 1'b0;
        cmderr_q    <= '0;
        cmd_q       <= '0;
      end else begin
        if (resumereq_q && hart_resumeack) begin
          resumereq_q <= 1'b0;
          resumeack_q <= 1'b1;
        end
        if (dmctl_wr && dmi_req_data[30] && !dmi_req_data[31]) begin
          resumereq_q <= 1'b1;
          resumeack_q <= 1'b0;
        end
        if (acs_wr) cmderr_q <= cmderr_q & ~dmi_req_data[10:8];
        if (cmd_wr) begin
          if (busy) begin
            if (cmderr_q == 3'd0) cmderr_q <= 3'd1;
          end else if (cmderr_q == 3'd0) begin
            cmd_q       <= dmi_req_data;
            cmd_valid_q <= 1'b1;
          end
        end
        if (data_acc && busy && cmderr_q == 3'd0) cmderr_q <= 3'd1;
        // Engine error is last so it beats a same-cycle W1C.
        if (cmd_done && cmd_err != 3'd0 && cmderr_q == 3'd0) cmderr_q <= cmd_err;
      end
    end
  end

  // ---------------------------------------------------------------- data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else begin
      for (int j = 0; j < DATACOUNT; j++) begin
        if (hold)
          data_q[j] <= '0;
        else if (data_we && data_idx == 4'(j))
          data_q[j] <= data_wdata;
        else if (wr_en && is_data && !busy && data_off == 7'(j))
          data_q[j] <= dmi_req_data;
      end
    end
  end

  assign hart_haltreq   = haltreq_q && dmactive_q;
  assign hart_resumereq = resumereq_q;
  assign dmactive       = dmactive_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd            = cmd_q;

endmodule

// File: tb/tb_debug_dm_regs.sv
// Directed bench for debug_dm_regs: a DMI vector table followed by
// hand-written sequences for resume, command/cmderr, back-pressure and reset.
module tb_debug_dm_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid, dmi_rsp_ready;
  logic [31:0] dmi_rsp_data;
  logic [1:0]  dmi_rsp_op;
  logic        hart_halted, hart_running, hart_resumeack;
  logic        hart_haltreq, hart_resumereq, dmactive;
  logic        cmd_valid;
  logic [31:0] cmd;
  logic        cmd_busy, cmd_done;
  logic [2:0]  cmd_err;
  logic        data_we;
  logic [3:0]  data_idx;
  logic [31:0] data_wdata;

  int n_chk  = 0;
  int n_fail = 0;
  int vcnt   = 0;
  logic we_with_req = 1'b0;

  always #5 clk = ~clk;

  debug_dm_regs #(.DATACOUNT(1), .VERSION(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op),
    .hart_halted(hart_halted), .hart_running(hart_running), .hart_resumeack(hart_resumeack),
    .hart_haltreq(hart_haltreq), .hart_resumereq(hart_resumereq), .dmactive(dmactive),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .cmd_err(cmd_err), .data_we(data_we), .data_idx(data_idx), .data_wdata(data_wdata)
  );

  always @(negedge clk) if (cmd_valid) vcnt++;

  typedef struct packed {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  eop;
    logic [31:0] edata;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One DMI transaction; returns the response fields.
  task automatic dmi_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] ro);
    int n;
    n = 0;
    while (!dmi_req_ready && n < 20) begin tick(); n++; end
    if (!dmi_req_ready) chk("req_ready_timeout", 32'(dmi_req_ready), 32'd1);
    dmi_req_valid = 1'b1; dmi_req_op = op; dmi_req_addr = addr; dmi_req_data = wd;
    if (we_with_req) data_we = 1'b1;
    tick();
    dmi_req_valid = 1'b0; data_we = 1'b0;
    n = 0;
    while (!dmi_rsp_valid && n < 20) begin tick(); n++; end
    if (!dmi_rsp_valid) chk("rsp_valid_timeout", 32'(dmi_rsp_valid), 32'd1);
    rd = dmi_rsp_data; ro = dmi_rsp_op;
    dmi_rsp_ready = 1'b1;
    tick();
    dmi_rsp_ready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic [1:0] ro;
    dmi_txn(2'd1, addr, 32'h0, rd, ro);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic [1:0] ro;
    dmi_txn(2'd2, addr, wd, rd, ro);
  endtask

  initial begin
    logic [31:0] rd, hold_data;
    logic [1:0]  ro;

    rst_n = 1'b0;
    dmi_req_valid = 0; dmi_req_addr = 0; dmi_req_data = 0; dmi_req_op = 0; dmi_rsp_ready = 0;
    hart_halted = 0; hart_running = 0; hart_resumeack = 0;
    cmd_busy = 0; cmd_done = 0; cmd_err = 0; data_we = 0; data_idx = 0; data_wdata = 0;
    repeat (3) tick();

    // reset state
    chk("rst_rsp_valid", 32'(dmi_rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(dmi_req_ready), 32'd1);
    chk("rst_dmactive",  32'(dmactive),      32'd0);
    chk("rst_haltreq",   32'(hart_haltreq),  32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid),     32'd0);
    chk("rst_cmd",       cmd,                32'd0);
    chk("rst_rsp_data",  dmi_rsp_data,       32'd0);
    rst_n = 1'b1;
    tick();

    // op, addr, wdata, expected rsp op, expected rsp data
    tv.push_back('{2'd1, 7'h11, 32'h0,        2'd0, 32'h00000083});
    tv.push_back('{2'd2, 7'h04, 32'hDEADBEEF, 2'd0, 32'h0});
    tv.push_back('{2'd1, 7'h04, 32'h0,        2'd0, 32'h0});
    tv.push_back('{2'd2, 7'h10, 32'h00000001, 2'd0, 32'h0});
    tv.push_back('{2'd1, 7'h10, 32'h0,        2'd0, 32'h00000001});
    tv.push_back('{2'd2, 7'h04, 32'hDEADBEEF, 2'd0, 32'h0});
    tv.push_back('{2'd1, 7'h04, 32'h0,        2'd0, 32'hDEADBEEF});
    tv.push_back('{2'd1, 7'h16, 32'h0,        2'd0, 32'h00000001});
    tv.push_back('{2'd1, 7'h38, 32'h0,        2'd0, 32'h20000000});
    tv.push_back('{2'd1, 7'h7F, 32'h0,        2'd0, 32'h0});
    tv.push_back('{2'd2, 7'h7F, 32'hFFFFFFFF, 2'd0, 32'h0});
    tv.push_back('{2'd3, 7'h04, 32'h11111111, 2'd2, 32'h0});
    tv.push_back('{2'd3, 7'h11, 32'h0,        2'd2, 32'h0});
    tv.push_back('{2'd1, 7'h04, 32'h0,        2'd0, 32'hDEADBEEF});
    tv.push_back('{2'd0, 7'h04, 32'h0,        2'd0, 32'h0});
    tv.push_back('{2'd1, 7'h05, 32'h0,        2'd0, 32'h0});
    tv.push_back('{2'd2, 7'h11, 32'hFFFFFFFF, 2'd0, 32'h0});
    tv.push_back('{2'd1, 7'h11, 32'h0,        2'd0, 32'h00000083});

    foreach (tv[i]) begin
      dmi_txn(tv[i].op, tv[i].addr, tv[i].wdata, rd, ro);
      chk($sformatf("vec%0d_data", i), rd, tv[i].edata);
      chk($sformatf("vec%0d_op", i), 32'(ro), 32'(tv[i].eop));
    end

    // halt request and dmstatus halted view
    wr(7'h10, 32'h80000001);
    chk("halt_dmactive", 32'(dmactive), 32'd1);
    chk("halt_haltreq",  32'(hart_haltreq), 32'd1);
    hart_halted = 1'b1;
    rd_chk("halt_dmstatus", 7'h11, 32'h00000383);

    // resume handshake
    hart_halted = 1'b0; hart_running = 1'b1;
    wr(7'h10, 32'h40000001);
    chk("resume_haltreq", 32'(hart_haltreq), 32'd0);
    chk("resume_req_set", 32'(hart_resumereq), 32'd1);
    repeat (3) tick();
    chk("resume_req_hold", 32'(hart_resumereq), 32'd1);
    hart_resumeack = 1'b1; tick(); hart_resumeack = 1'b0;
    chk("resume_req_clr", 32'(hart_resumereq), 32'd0);
    rd_chk("resume_dmstatus", 7'h11, 32'h00030C83);
    wr(7'h10, 32'hC0000001);
    chk("both_resumereq", 32'(hart_resumereq), 32'd0);
    chk("both_haltreq", 32'(hart_haltreq), 32'd1);
    wr(7'h10, 32'h00000001);

    // command issue and busy error
    vcnt = 0;
    wr(7'h17, 32'h00221000);
    chk("cmd_pulse_cnt", 32'(vcnt), 32'd1);
    chk("cmd_value", cmd, 32'h00221000);
    cmd_busy = 1'b1; vcnt = 0;
    wr(7'h17, 32'h11111111);
    chk("busy_no_pulse", 32'(vcnt), 32'd0);
    chk("busy_cmd_kept", cmd, 32'h00221000);
    rd_chk("busy_abstractcs", 7'h16, 32'h00001101);
    wr(7'h04, 32'h0);
    cmd_busy = 1'b0;
    rd_chk("busy_data_kept", 7'h04, 32'hDEADBEEF);
    vcnt = 0;
    wr(7'h17, 32'h22222222);
    chk("cmderr_blocks_cmd", 32'(vcnt), 32'd0);

    // cmderr W1C and engine error
    wr(7'h16, 32'h00000100);
    rd_chk("w1c_abstractcs", 7'h16, 32'h00000001);
    cmd_done = 1'b1; cmd_err = 3'd3; tick(); cmd_done = 1'b0; cmd_err = 3'd0;
    rd_chk("engine_err", 7'h16, 32'h00000301);
    wr(7'h16, 32'h00000700);
    rd_chk("w1c_all", 7'h16, 32'h00000001);
    cmd_busy = 1'b1;
    rd_chk("busy_data_read_val", 7'h04, 32'hDEADBEEF);
    cmd_busy = 1'b0;
    rd_chk("busy_read_cmderr", 7'h16, 32'h00000101);
    wr(7'h16, 32'h00000100);

    // engine data write beats a same-cycle DMI data write
    data_idx = 4'd0; data_wdata = 32'hCAFEF00D; we_with_req = 1'b1;
    wr(7'h04, 32'h12345678);
    we_with_req = 1'b0;
    rd_chk("data_we_wins", 7'h04, 32'hCAFEF00D);

    // response held under back-pressure
    dmi_req_valid = 1'b1; dmi_req_op = 2'd1; dmi_req_addr = 7'h10;
    tick();
    dmi_req_addr = 7'h11;
    hold_data = 32'h00000001;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_rsp_valid", k), 32'(dmi_rsp_valid), 32'd1);
      chk($sformatf("bp%0d_req_ready", k), 32'(dmi_req_ready), 32'd0);
      chk($sformatf("bp%0d_rsp_data", k), dmi_rsp_data, hold_data);
      tick();
    end
    dmi_req_valid = 1'b0;
    dmi_rsp_ready = 1'b1; tick(); dmi_rsp_ready = 1'b0;
    chk("bp_release", 32'(dmi_req_ready), 32'd1);

    // deactivation clears state synchronously
    wr(7'h10, 32'h00000000);
    chk("deact_dmactive", 32'(dmactive), 32'd0);
    wr(7'h10, 32'h00000001);
    rd_chk("deact_data_clr", 7'h04, 32'h0);

    // asynchronous reset while a response is pending
    wr(7'h10, 32'h80000001);
    dmi_req_valid = 1'b1; dmi_req_op = 2'd1; dmi_req_addr = 7'h10;
    tick();
    dmi_req_valid = 1'b0;
    chk("pre_rst_rsp_valid", 32'(dmi_rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(dmi_rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(dmi_req_ready), 32'd1);
    chk("arst_dmactive",  32'(dmactive),      32'd0);
    chk("arst_haltreq",   32'(hart_haltreq),  32'd0);
    chk("arst_rsp_data",  dmi_rsp_data,       32'd0);
    chk("arst_cmd",       cmd,                32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_chk("post_rst_dmcontrol", 7'h10, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debug_dm_regs.md
DEBUG_DM_REGS -- requirements
Module: debug_dm_regs

Interface
REQ-001 SHALL have parameter DATACOUNT, default 1, meaning the number of implemented data registers (1..12).
REQ-002 SHALL have parameter VERSION, default 3, meaning the value of dmstatus.version.
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have DMI request ports: dmi_req_valid in 1; dmi_req_ready out 1; dmi_req_addr in 7; dmi_req_data in 32; dmi_req_op in 2 (0 nop, 1 read, 2 write, 3 reserved).
REQ-006 SHALL have DMI response ports: dmi_rsp_valid out 1; dmi_rsp_ready in 1; dmi_rsp_data out 32; dmi_rsp_op out 2 (0 success, 2 failed).
REQ-007 SHALL have hart ports: hart_halted in 1; hart_running in 1; hart_resumeack in 1; hart_haltreq out 1; hart_resumereq out 1; dmactive out 1.
REQ-008 SHALL have abstract-engine ports: cmd_valid out 1; cmd out 32; cmd_busy in 1; cmd_done in 1; cmd_err in 3; data_we in 1; data_idx in 4; data_wdata in 32.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (dmi_req_ready=1) and RESP (dmi_rsp_valid=1, dmi_req_ready=0).
REQ-010 SHALL, in IDLE with dmi_req_valid=1, perform the access in that cycle and enter RESP; dmi_rsp_valid rises on the next cycle (latency 1).
REQ-011 SHALL hold dmi_rsp_data and dmi_rsp_op stable in RESP until dmi_rsp_ready=1, then return to IDLE; back-to-back accept is not required.
REQ-012 SHALL map addresses: 0x04..0x04+DATACOUNT-1 data0.., 0x10 dmcontrol, 0x11 dmstatus, 0x16 abstractcs, 0x17 command, 0x38 sbcs; other addresses read 0, writes ignored, op success.
REQ-013 SHALL answer op 3 with dmi_rsp_op=2 and data 0 and no side effect; op 0 with success and data 0.
REQ-014 SHALL, while dmactive=0, ignore writes to every register except dmcontrol and hold all other DM state at reset value.
REQ-015 SHALL store dmcontrol bits dmactive(0) and haltreq(31); hart_haltreq = stored haltreq AND dmactive.
REQ-016 SHALL, on a dmcontrol write with resumereq(30)=1 and haltreq=0, set hart_resumereq and clear the resume-ack flag; a write with both set ignores resumereq.
REQ-017 SHALL clear hart_resumereq and set the resume-ack flag on the first cycle hart_resumeack=1.
REQ-018 SHALL read dmstatus as: version=VERSION, authenticated=1, all/anyhalted=hart_halted, all/anyrunning=hart_running, all/anyresumeack=resume-ack flag, other bits 0; writes ignored.
REQ-019 SHALL read abstractcs as: datacount=DATACOUNT, progbufsize=0, busy=cmd_busy OR cmd_valid, cmderr(10:8)=stored value.
REQ-020 SHALL clear each cmderr bit written 1 in an abstractcs write (W1C); other abstractcs bits are read-only.
REQ-021 SHALL, on a command write with busy=1, set cmderr=1 if cmderr=0 and issue nothing.
REQ-022 SHALL, on a command write with busy=0 and cmderr=0, latch cmd and pulse cmd_valid for exactly one cycle; with cmderr!=0 the write is ignored.
REQ-023 SHALL, on a data-register write or read while busy=1, set cmderr=1 if cmderr=0 and leave the register unchanged.
REQ-024 SHALL, on cmd_done=1 with cmd_err!=0 and cmderr=0, load cmderr from cmd_err; a simultaneous DMI W1C loses to the engine error.
REQ-025 SHALL write data[data_idx]=data_wdata when data_we=1; data_we wins over a same-cycle DMI data write.
REQ-026 SHALL read sbcs as version=1 with all other fields 0; writes ignored.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously clear FSM to IDLE, all registers, cmderr, resume-ack flag, hart_haltreq, hart_resumereq, cmd_valid, dmi_rsp_valid, dmactive; cmd and dmi_rsp_data reset to 0.
REQ-028 SHALL, on a dmcontrol write with dmactive=0, apply the same clear synchronously, excluding FSM state and the pending response.

Verification
REQ-029 SHALL cover: write dmcontrol 0x80000001 -> dmactive=1, hart_haltreq=1; hart_halted=1 then read 0x11 -> allhalted=anyhalted=1, version=3.
REQ-030 SHALL cover: write 0x40000001 -> hart_resumereq=1 until hart_resumeack pulse, then 0; dmstatus allresumeack=1.
REQ-031 SHALL cover: write command 0x00221000 with cmd_busy=0 -> one-cycle cmd_valid, cmd=0x00221000; second write while cmd_busy=1 -> cmderr=1, no cmd_valid.
REQ-032 SHALL cover: cmderr=1, write abstractcs 0x00000100 -> cmderr=0; cmd_done with cmd_err=3 -> cmderr=3.
REQ-033 SHALL cover: op 3 to any address -> dmi_rsp_op=2; read 0x7F -> data 0, op 0; rsp_ready held low 5 cycles -> response stable, req_ready=0.
REQ-034 SHALL cover: rst_n low mid-RESP -> dmi_rsp_valid=0 immediately, all outputs at reset values.
